// File: rtl/memory_arbiter_pkg.sv
// Shared types for the multicore RAM arbiter: RAM word/state types, arbiter FSM states
// and requester-count derivations.
package memory_arbiter_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_t;

   // Each core contributes a dcache (even index) and an icache (odd index) requester.
   function automatic int unsigned reqs_of(input int unsigned cpus);
      return 2 * cpus;
   endfunction

   function automatic int unsigned idx_w_of(input int unsigned reqs);
      return (reqs > 1) ? $clog2(reqs) : 1;
   endfunction

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_picker #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IDX_W'((32'(ptr_i) + k) % N);
         if (!valid_o && req_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin owner arbiter sharing one single-ported RAM among the instruction and
// data ports of CPUS cores, with optional bounded lock for data block transfers.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int unsigned CPUS     = 2,
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic [CPUS-1:0] iREN,
   input  word_t           iaddr    [CPUS],
   input  logic [CPUS-1:0] dREN,
   input  logic [CPUS-1:0] dWEN,
   input  word_t           daddr    [CPUS],
   input  word_t           dstore   [CPUS],
   input  logic [CPUS-1:0] dlock,
   output logic [CPUS-1:0] iwait,
   output logic [CPUS-1:0] dwait,
   output word_t           iload    [CPUS],
   output word_t           dload    [CPUS],
   output logic [CPUS-1:0] derr,
   output logic [CPUS-1:0] ierr,
   output word_t           ramaddr,
   output word_t           ramstore,
   output logic            ramREN,
   output logic            ramWEN,
   input  word_t           ramload,
   input  ramstate_t       ramstate
);

   localparam int unsigned REQS  = reqs_of(CPUS);
   localparam int unsigned IDX_W = idx_w_of(REQS);
   localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] hold_q, hold_d;

   logic [REQS-1:0]  req_vec;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;

   logic             own_req, own_ren, own_wen, own_lock, own_is_data;
   word_t            own_addr, own_store;
   logic             done_c, err_c, keep_c;
   logic [IDX_W-1:0] next_ptr;

   always_comb begin
      req_vec = '0;
      for (int unsigned c = 0; c < CPUS; c++) begin
         req_vec[2*c]   = dREN[c] | dWEN[c];
         req_vec[2*c+1] = iREN[c];
      end
   end

   rr_picker #(
      .N     (REQS),
      .IDX_W (IDX_W)
   ) u_rr_picker (
      .req_i   (req_vec),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   // Owner's request view; write wins over read on a data port.
   always_comb begin
      own_req     = 1'b0;
      own_ren     = 1'b0;
      own_wen     = 1'b0;
      own_lock    = 1'b0;
      own_is_data = 1'b0;
      own_addr    = '0;
      own_store   = '0;
      for (int unsigned c = 0; c < CPUS; c++) begin
         if (owner_q == IDX_W'(2*c)) begin
            own_req     = dREN[c] | dWEN[c];
            own_ren     = dREN[c] & ~dWEN[c];
            own_wen     = dWEN[c];
            own_lock    = dlock[c];
            own_is_data = 1'b1;
            own_addr    = daddr[c];
            own_store   = dstore[c];
         end
         if (owner_q == IDX_W'(2*c+1)) begin
            own_req  = iREN[c];
            own_ren  = 1'b1;
            own_addr = iaddr[c];
         end
      end
   end

   assign done_c   = (state_q == OWN) && own_req && (ramstate == ACCESS);
   assign err_c    = (state_q == OWN) && own_req && (ramstate == ERROR);
   assign keep_c   = own_is_data && own_lock && ((32'(hold_q) + 32'd1) < HOLD_MAX);
   assign next_ptr = (owner_q == IDX_W'(REQS - 1)) ? '0 : owner_q + IDX_W'(1);

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      hold_d   = hold_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = OWN;
               owner_d = pick_idx;
               hold_d  = '0;
            end
         end
         OWN: begin
            if (!own_req) begin
               state_d = IDLE;
            end else if (done_c) begin
               if (keep_c) begin
                  hold_d = hold_q + CNT_W'(1);
               end else begin
                  state_d  = IDLE;
                  rr_ptr_d = next_ptr;
               end
            end else if (err_c) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         hold_q   <= hold_d;
      end
   end

   // RAM drive and per-port handshake follow the state register, so async reset clears them at once.
   always_comb begin
      ramaddr  = '0;
      ramstore = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      iwait    = '1;
      dwait    = '1;
      ierr     = '0;
      derr     = '0;
      if (state_q == OWN) begin
         ramaddr  = own_addr;
         ramstore = own_store;
         ramREN   = own_ren;
         ramWEN   = own_wen;
      end
      for (int unsigned c = 0; c < CPUS; c++) begin
         iload[c] = ramload;
         dload[c] = ramload;
         if (owner_q == IDX_W'(2*c)) begin
            dwait[c] = ~done_c;
            derr[c]  = err_c;
         end
         if (owner_q == IDX_W'(2*c+1)) begin
            iwait[c] = ~done_c;
            ierr[c]  = err_c;
         end
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: bench acts as the RAM and checks grant order,
// RAM drive, completion/error handshakes and reset behaviour.
module tb_memory_arbiter;
   import memory_arbiter_pkg::*;

   localparam int unsigned CPUS     = 2;
   localparam int unsigned HOLD_MAX = 8;

   logic            CLK = 1'b0;
   logic            nRST;
   logic [CPUS-1:0] iREN, dREN, dWEN, dlock;
   logic [CPUS-1:0] iwait, dwait, derr, ierr;
   word_t           iaddr [CPUS];
   word_t           daddr [CPUS];
   word_t           dstore[CPUS];
   word_t           iload [CPUS];
   word_t           dload [CPUS];
   word_t           ramaddr, ramstore, ramload;
   logic            ramREN, ramWEN;
   ramstate_t       ramstate;

   int errors   = 0;
   int checks   = 0;
   int cycle_no = 0;
   int exp_q[$];
   int done_cyc[$];

   memory_arbiter #(.CPUS(CPUS), .HOLD_MAX(HOLD_MAX)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dlock(dlock),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .derr(derr), .ierr(ierr),
      .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Index of the single requester whose wait is low; -1 none, -2 more than one.
   function automatic int winner();
      int w = -1;
      int n = 0;
      for (int c = 0; c < int'(CPUS); c++) begin
         if (dwait[c] === 1'b0) begin w = 2*c;   n++; end
         if (iwait[c] === 1'b0) begin w = 2*c+1; n++; end
      end
      return (n > 1) ? -2 : w;
   endfunction

   task automatic set_defaults();
      iREN = '0; dREN = '0; dWEN = '0; dlock = '0;
      ramload = 32'h0; ramstate = FREE;
      for (int c = 0; c < int'(CPUS); c++) begin
         daddr[c]  = 32'h1000 + 32'(c) * 32'h10;
         iaddr[c]  = 32'h2000 + 32'(c) * 32'h10;
         dstore[c] = 32'hA000_0000 + 32'(c);
      end
   endtask

   task automatic drop_all();
      @(negedge CLK);
      iREN = '0; dREN = '0; dWEN = '0; dlock = '0; ramstate = FREE;
      @(negedge CLK);
   endtask

   // RAM model answers ACCESS after `busy` BUSY cycles; each completion pops the scoreboard.
   task automatic run_grants(input int busy, input int budget);
      int cnt = 0;
      int got, exp, c;
      word_t e_addr, e_store;
      logic  e_ren, e_wen;
      for (int cyc = 0; cyc < budget && exp_q.size() > 0; cyc++) begin
         @(negedge CLK);
         cycle_no++;
         if (ramREN || ramWEN) begin
            if (cnt < busy) begin ramstate = BUSY; cnt++; end
            else begin ramstate = ACCESS; cnt = 0; end
         end else begin
            ramstate = FREE; cnt = 0;
         end
         #1;
         got = winner();
         if (got != -1) begin
            exp = exp_q.pop_front();
            done_cyc.push_back(cycle_no);
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL grant_order got=%0d exp=%0d", got, exp);
            end
            c = exp / 2;
            if (exp % 2 == 1) begin
               e_addr = iaddr[c]; e_ren = 1'b1; e_wen = 1'b0; e_store = 32'h0;
            end else begin
               e_addr = daddr[c]; e_wen = dWEN[c]; e_ren = dREN[c] & ~dWEN[c]; e_store = dstore[c];
            end
            checks++;
            if (ramaddr !== e_addr || ramREN !== e_ren || ramWEN !== e_wen || ramstore !== e_store) begin
               errors++;
               $display("FAIL ram_drive req=%0d got addr=%h ren=%b wen=%b store=%h exp addr=%h ren=%b wen=%b store=%h",
                        exp, ramaddr, ramREN, ramWEN, ramstore, e_addr, e_ren, e_wen, e_store);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL grant_timeout pending=%0d exp=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (iwait !== '1 || dwait !== '1 || ierr !== '0 || derr !== '0 ||
          ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
         errors++;
         $display("FAIL %s got iwait=%b dwait=%b ierr=%b derr=%b ren=%b wen=%b addr=%h store=%h exp 11 11 00 00 0 0 0 0",
                  tag, iwait, dwait, ierr, derr, ramREN, ramWEN, ramaddr, ramstore);
      end
   endtask

   task automatic test_reset();
      set_defaults();
      nRST = 1'b0;
      ramstate = ACCESS;
      repeat (2) @(negedge CLK);
      #1;
      check_reset_outputs("reset_values");
      ramstate = FREE;
      nRST = 1'b1;
   endtask

   task automatic test_single_iread();
      int lows = 0;
      @(negedge CLK);
      iaddr[0] = 32'h40; iREN[0] = 1'b1; ramload = 32'hCAFE_0001;
      @(negedge CLK); ramstate = BUSY; #1;
      checks++;
      if (ramaddr !== 32'h40 || ramREN !== 1'b1 || ramWEN !== 1'b0) begin
         errors++;
         $display("FAIL iread_drive got addr=%h ren=%b wen=%b exp 40 1 0", ramaddr, ramREN, ramWEN);
      end
      checks++;
      if (iload[0] !== 32'hCAFE_0001 || dload[1] !== 32'hCAFE_0001) begin
         errors++;
         $display("FAIL load_bcast got i=%h d=%h exp cafe0001", iload[0], dload[1]);
      end
      if (iwait[0] === 1'b0) lows++;
      @(negedge CLK); ramstate = BUSY; #1;
      if (iwait[0] === 1'b0) lows++;
      @(negedge CLK); ramstate = ACCESS; #1;
      checks++;
      if (iwait[0] !== 1'b0) begin
         errors++;
         $display("FAIL iread_done got iwait0=%b exp 0", iwait[0]);
      end
      if (iwait[0] === 1'b0) lows++;
      @(negedge CLK); iREN[0] = 1'b0; ramstate = FREE;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (iwait[0] === 1'b0) lows++;
         @(negedge CLK);
      end
      checks++;
      if (lows != 1) begin
         errors++;
         $display("FAIL iread_once got lows=%0d exp 1", lows);
      end
      iaddr[0] = 32'h2000;
   endtask

   // rr_ptr should be 2 after the icache of core 0 finished.
   task automatic test_round_robin();
      @(negedge CLK);
      dREN = '1; iREN = '1;
      exp_q = '{2, 3, 0, 1, 2, 3, 0, 1};
      run_grants(1, 200);
      drop_all();
   endtask

   task automatic test_lock_burst();
      @(negedge CLK);
      dREN[1] = 1'b1; dlock[1] = 1'b1; iREN[1] = 1'b1; dREN[0] = 1'b1;
      done_cyc.delete();
      for (int i = 0; i < int'(HOLD_MAX); i++) exp_q.push_back(2);
      exp_q.push_back(3);
      run_grants(0, 100);
      checks++;
      if (done_cyc.size() != int'(HOLD_MAX) + 1) begin
         errors++;
         $display("FAIL lock_count got=%0d exp=%0d", done_cyc.size(), HOLD_MAX + 1);
      end else begin
         int consec = 0;
         for (int i = 0; i < int'(HOLD_MAX) - 1; i++)
            if (done_cyc[i+1] - done_cyc[i] == 1) consec++;
         checks++;
         if (consec != int'(HOLD_MAX) - 1) begin
            errors++;
            $display("FAIL lock_no_bubble got=%0d exp=%0d", consec, HOLD_MAX - 1);
         end
         checks++;
         if (done_cyc[HOLD_MAX] - done_cyc[HOLD_MAX-1] != 2) begin
            errors++;
            $display("FAIL lock_release_gap got=%0d exp=2", done_cyc[HOLD_MAX] - done_cyc[HOLD_MAX-1]);
         end
      end
      drop_all();
   endtask

   task automatic test_write_wins();
      @(negedge CLK);
      dWEN[0] = 1'b1; dREN[0] = 1'b1; dstore[0] = 32'hDEAD_BEEF;
      exp_q.push_back(0);
      run_grants(1, 20);
      checks++;
      if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL write_wins got wen=%b ren=%b store=%h exp 1 0 deadbeef", ramWEN, ramREN, ramstore);
      end
      drop_all();
   endtask

   // rr_ptr is 1 here; requester 2 wins, errors, and the pointer must move to 3.
   task automatic test_error();
      @(negedge CLK);
      dREN[1] = 1'b1;
      @(negedge CLK); ramstate = ERROR; #1;
      checks++;
      if (derr[1] !== 1'b1 || dwait[1] !== 1'b1 || derr[0] !== 1'b0 || ierr !== '0) begin
         errors++;
         $display("FAIL err_pulse got derr=%b dwait1=%b ierr=%b exp derr=10 dwait1=1 ierr=00", derr, dwait[1], ierr);
      end
      @(negedge CLK); ramstate = FREE; iREN = '1; #1;
      checks++;
      if (derr !== '0 || ramREN !== 1'b0 || dwait[1] !== 1'b1) begin
         errors++;
         $display("FAIL err_to_idle got derr=%b ren=%b dwait1=%b exp 00 0 1", derr, ramREN, dwait[1]);
      end
      exp_q = '{3, 1, 2};
      run_grants(1, 100);
      drop_all();
   endtask

   task automatic test_reset_mid_burst();
      @(negedge CLK);
      dREN[0] = 1'b1; dlock[0] = 1'b1;
      exp_q = '{0, 0, 0};
      run_grants(0, 20);
      @(negedge CLK); ramstate = ACCESS; #1;
      checks++;
      if (ramREN !== 1'b1 || dwait[0] !== 1'b0) begin
         errors++;
         $display("FAIL burst_active got ren=%b dwait0=%b exp 1 0", ramREN, dwait[0]);
      end
      #1 nRST = 1'b0;
      #1;
      check_reset_outputs("reset_mid_burst");
      @(negedge CLK);
      dlock = '0; iREN = '1; dREN = '1; ramstate = FREE; nRST = 1'b1;
      exp_q = '{0, 1};
      run_grants(1, 40);
      drop_all();
   endtask

   initial begin
      test_reset();
      test_single_iread();
      test_round_robin();
      test_lock_burst();
      test_write_wins();
      test_error();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Parametrised RAM arbiter for the multicore memory system: `CPUS` cores, each with an instruction port and a data port, share one single-ported RAM. Round-robin arbitration across all `2*CPUS` requesters replaces the fixed data-over-instruction priority of the single-core controller. A registered owner FSM holds the RAM for one requester at a time, with an optional lock for multi-word cache block transfers. Sits between the caches and `ram`, inside the memory-control wrapper.

## Interface
- `CPUS`, 2, number of cores; requester `2c` = dcache of core `c`, `2c+1` = icache of core `c`.
- `HOLD_MAX`, 8, maximum consecutive completed words one locked owner may take before forced release; must be ≥1.
- `CLK` in 1: single clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `iREN` in [CPUS]: instruction read request.
- `iaddr` in [CPUS] x word_t: instruction address.
- `dREN`, `dWEN` in [CPUS]: data read/write request.
- `daddr`, `dstore` in [CPUS] x word_t: data address, write data.
- `dlock` in [CPUS]: keep grant after the current word (block transfer).
- `iwait`, `dwait` out [CPUS]: 1 = stall; 0 = word done this cycle.
- `iload`, `dload` out [CPUS] x word_t: read data.
- `derr`, `ierr` out [CPUS]: one-cycle pulse, RAM reported ERROR for this port's access.
- `ramaddr`, `ramstore` out word_t; `ramREN`, `ramWEN` out 1.
- `ramload` in word_t; `ramstate` in ramstate_t (FREE, BUSY, ACCESS, ERROR).

## Operation
- States: IDLE, OWN. Registers: `owner` (index, `$clog2(2*CPUS)` bits), `rr_ptr` (same width), `hold_cnt` (`$clog2(HOLD_MAX+1)` bits).
- Request of requester r: data = `dREN|dWEN`; instr = `iREN`.
- IDLE: search r = `rr_ptr`, `rr_ptr+1`, ... mod `2*CPUS`; first requester found → `owner`, `hold_cnt`=0, go OWN. No requester → stay IDLE. RAM outputs REN=WEN=0, `ramaddr`=0.
- OWN: RAM driven from owner only. Data owner: `ramaddr`=`daddr`, `ramstore`=`dstore`, `ramWEN`=`dWEN`, `ramREN`=`dREN & ~dWEN` (write wins when both are high). Instr owner: `ramaddr`=`iaddr`, `ramREN`=1, `ramWEN`=0.
- Completion: `ramstate==ACCESS` in OWN → owner's wait=0 that cycle. All other waits stay 1 in all cases.
- After completion: if the owner is a data port, its `dlock` is high, it still requests, and `hold_cnt+1 < HOLD_MAX` → stay OWN and increment `hold_cnt`. Otherwise → IDLE, `rr_ptr` = owner+1 mod `2*CPUS`.
- ERROR in OWN: the owner's err pulses for 1 cycle; wait stays 1; go IDLE; `rr_ptr` = owner+1.
- Owner drops its request in OWN without completion: go IDLE next edge, no wait/err pulse, `rr_ptr` unchanged.
- `iload[c]`=`dload[c]`=`ramload` for all c (combinational); only wait qualifies the data.
- Locks on icache ports do not exist. `dlock` without a request is ignored.

## Timing
- Reset values: state IDLE, `owner`=0, `rr_ptr`=0, `hold_cnt`=0; all waits 1, errs 0, REN/WEN 0, `ramaddr`/`ramstore` 0.
- Grant latency: a request present in IDLE at edge k drives the RAM from cycle k+1.
- Wait-low is combinational from `ramstate` in the same cycle. There is one IDLE bubble cycle between different owners. A locked burst has no bubble.
- Request inputs must stay stable while wait=1; the arbiter does not latch address or data.
- Reset mid-OWN: outputs return to reset values immediately (async). The RAM request drops with them.
- `HOLD_MAX`=1: a lock never extends a grant.

## Structure
- `ramstate_t`, word_t: existing `cpu_types_pkg`. Add to the package `localparam`-style helper `REQS = 2*CPUS` derivations and `arb_state_t` {IDLE, OWN}.
- One sub-module, `rr_picker`: combinational; takes the request vector and `rr_ptr`; outputs `valid` and the winner index. It is reused later by the coherence bus arbiter.

## Test plan
- CPUS=2, reset, then `iREN[0]`, `iaddr[0]`=0x40, RAM ACCESS after 2 BUSY cycles → `ramaddr`=0x40 from cycle 1, `iwait[0]`=0 exactly once, `rr_ptr`=2.
- All four requesters active continuously, single-word accesses → grants go 0,1,2,3,0; no requester waits more than 3 grants.
- `dREN[1]`+`dlock[1]` held, HOLD_MAX=8 → exactly 8 consecutive `dwait[1]` lows with no bubble, then forced release to requester 3 (or next pending).
- `dWEN[0]`=`dREN[0]`=1, `dstore[0]`=0xDEADBEEF → `ramWEN`=1, `ramREN`=0, `ramstore`=0xDEADBEEF.
- `ramstate`=ERROR during the owner's access → `derr` one-cycle pulse, `dwait` stays 1, arbiter returns to IDLE and advances `rr_ptr`.
- `nRST` asserted mid-burst → all outputs at reset values in the same cycle; the first grant after reset goes to requester 0.
